// File: rtl/sched_pkg.sv
// Shared encodings for the context-switch scheduler: process-table entry states,
// controller states, switch reasons and the default OS entry PC.
package sched_pkg;

  typedef enum logic [1:0] {
    P_FREE    = 2'd0,
    P_READY   = 2'd1,
    P_RUNNING = 2'd2,
    P_BLOCKED = 2'd3
  } proc_st_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAVE   = 2'd1,
    S_SELECT = 2'd2,
    S_LOAD   = 2'd3
  } fsm_st_e;

  typedef enum logic [1:0] {
    R_TROCA = 2'd0,
    R_IO    = 2'd1,
    R_FIM   = 2'd2
  } reason_e;

  localparam logic [31:0] SO_PC_DEFAULT = 32'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over the READY mask, searching upward from
// start_i with wrap-around; PID 0 (the OS) is never granted.
module rr_arbiter #(
  parameter int NUM_PROCS = 8,
  parameter int PID_W     = 3
) (
  input  logic [NUM_PROCS-1:0] ready_mask_i,
  input  logic [PID_W-1:0]     start_i,
  output logic [PID_W-1:0]     grant_o,
  output logic                 grant_valid_o
);

  logic [PID_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest READY candidate wins.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    for (int k = NUM_PROCS - 1; k >= 0; k--) begin
      cand = start_i + k[PID_W-1:0];
      if ((cand != '0) && ready_mask_i[cand]) begin
        grant_o       = cand;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/context_switch_scheduler.sv
// Context-switch responder: saves the preempted PC, picks the next READY process
// round-robin and reloads the PC. Optional SCHED_STATS_EN adds switch/IO counters.
//
// state  | meaning
// IDLE   | waiting for a request edge, OS dispatch or process create
// SAVE   | write back the outgoing process entry (state + PC)
// SELECT | round-robin pick among READY entries, PID 0 if none
// LOAD   | pc_load strobe with pc_novo / processo_atual of the pick
module context_switch_scheduler
  import sched_pkg::*;
#(
  parameter int          NUM_PROCS = 8,
  parameter int          PID_W     = 3,
  parameter logic [31:0] SO_PC     = SO_PC_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             troca_contexto,
  input  logic             io_contexto,
  input  logic             fim_processo,
  input  logic [31:0]      pc_processo_trocado,
  input  logic             io_done,
  input  logic [PID_W-1:0] io_done_pid,
  input  logic             create_valid,
  input  logic [PID_W-1:0] create_pid,
  input  logic [31:0]      create_pc,
  output logic             create_ready,
  output logic [31:0]      pc_novo,
  output logic             pc_load,
  output logic [PID_W-1:0] processo_atual,
  output logic             busy
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]      switch_count,
  output logic [31:0]      io_block_count
`endif
);

  fsm_st_e          state_q;
  reason_e          reason_q;
  logic             troca_prev_q;
  logic             io_prev_q;
  logic             fim_prev_q;
  logic [31:0]      pc_novo_q;
  logic             pc_load_q;
  logic [PID_W-1:0] pa_q;

  proc_st_e         st_tab_q [NUM_PROCS];
  proc_st_e         st_tab_d [NUM_PROCS];
  logic [31:0]      pc_tab_q [NUM_PROCS];
  logic [31:0]      pc_tab_d [NUM_PROCS];

  logic             troca_edge;
  logic             io_edge;
  logic             fim_edge;
  logic             is_idle;
  logic             req_go;
  logic             os_go;
  logic             create_acc;
  logic [NUM_PROCS-1:0] ready_mask;
  logic [PID_W-1:0] grant_pid;
  logic             grant_valid;

  assign troca_edge = troca_contexto & ~troca_prev_q;
  assign io_edge    = io_contexto & ~io_prev_q;
  assign fim_edge   = fim_processo & ~fim_prev_q;
  assign is_idle    = (state_q == S_IDLE);

  // The OS (PID 0) never raises requests of its own; it only leaves via dispatch.
  assign req_go = is_idle && (pa_q != '0) && (troca_edge || io_edge || fim_edge);
  assign os_go  = is_idle && (pa_q == '0) && (ready_mask != '0);

  assign create_ready = is_idle && !req_go;
  assign create_acc   = create_valid && create_ready && (create_pid != '0) &&
                        ((st_tab_q[create_pid] == P_FREE) ||
                         (st_tab_q[create_pid] == P_BLOCKED));

  always_comb begin
    ready_mask = '0;
    for (int i = 1; i < NUM_PROCS; i++) begin
      ready_mask[i] = (st_tab_q[i] == P_READY);
    end
  end

  rr_arbiter #(
    .NUM_PROCS (NUM_PROCS),
    .PID_W     (PID_W)
  ) u_rr_arbiter (
    .ready_mask_i  (ready_mask),
    .start_i       (pa_q + PID_W'(1)),
    .grant_o       (grant_pid),
    .grant_valid_o (grant_valid)
  );

  // Table next-state; io_done is applied last so it sees the SAVE result.
  always_comb begin
    st_tab_d = st_tab_q;
    pc_tab_d = pc_tab_q;
    if (create_acc) begin
      st_tab_d[create_pid] = P_READY;
      pc_tab_d[create_pid] = create_pc;
    end
    if (state_q == S_SAVE) begin
      unique case (reason_q)
        R_TROCA: begin
          st_tab_d[pa_q] = P_READY;
          pc_tab_d[pa_q] = pc_processo_trocado;
        end
        R_IO: begin
          st_tab_d[pa_q] = P_BLOCKED;
          pc_tab_d[pa_q] = pc_processo_trocado;
        end
        default: st_tab_d[pa_q] = P_FREE;
      endcase
    end
    if ((state_q == S_SELECT) && grant_valid) begin
      st_tab_d[grant_pid] = P_RUNNING;
    end
    if (io_done && (st_tab_d[io_done_pid] == P_BLOCKED)) begin
      st_tab_d[io_done_pid] = P_READY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      reason_q     <= R_TROCA;
      troca_prev_q <= 1'b0;
      io_prev_q    <= 1'b0;
      fim_prev_q   <= 1'b0;
      pc_novo_q    <= SO_PC;
      pc_load_q    <= 1'b0;
      pa_q         <= '0;
      for (int i = 0; i < NUM_PROCS; i++) begin
        st_tab_q[i] <= P_FREE;
        pc_tab_q[i] <= '0;
      end
    end else begin
      troca_prev_q <= troca_contexto;
      io_prev_q    <= io_contexto;
      fim_prev_q   <= fim_processo;
      st_tab_q     <= st_tab_d;
      pc_tab_q     <= pc_tab_d;
      unique case (state_q)
        S_IDLE: begin
          if (req_go) begin
            state_q  <= S_SAVE;
            reason_q <= fim_edge ? R_FIM : (io_edge ? R_IO : R_TROCA);
          end else if (os_go) begin
            state_q <= S_SELECT;
          end
        end
        S_SAVE: state_q <= S_SELECT;
        S_SELECT: begin
          state_q   <= S_LOAD;
          pc_load_q <= 1'b1;
          if (grant_valid) begin
            pc_novo_q <= pc_tab_q[grant_pid];
            pa_q      <= grant_pid;
          end else begin
            pc_novo_q <= SO_PC;
            pa_q      <= '0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          pc_load_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_novo        = pc_novo_q;
  assign pc_load        = pc_load_q;
  assign processo_atual = pa_q;
  assign busy           = !is_idle;

`ifdef SCHED_STATS_EN
  logic [31:0] switch_cnt_q;
  logic [31:0] io_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      switch_cnt_q <= '0;
      io_cnt_q     <= '0;
    end else begin
      if (state_q == S_SELECT) begin
        switch_cnt_q <= switch_cnt_q + 32'd1;
      end
      if ((state_q == S_SAVE) && (reason_q == R_IO)) begin
        io_cnt_q <= io_cnt_q + 32'd1;
      end
    end
  end

  assign switch_count   = switch_cnt_q;
  assign io_block_count = io_cnt_q;
`endif

endmodule

// File: tb/tb_context_switch_scheduler.sv
// Bench for context_switch_scheduler: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a table-level model.
module tb_context_switch_scheduler;

  localparam int N = 8;
  localparam int FREE = 0, READY = 1, RUNNING = 2, BLOCKED = 3;
  localparam logic [31:0] OS_PC = 32'd0;

  logic        clock = 1'b0;
  logic        reset;
  logic        troca_contexto, io_contexto, fim_processo;
  logic [31:0] pc_processo_trocado;
  logic        io_done;
  logic [2:0]  io_done_pid;
  logic        create_valid;
  logic [2:0]  create_pid;
  logic [31:0] create_pc;
  logic        create_ready;
  logic [31:0] pc_novo;
  logic        pc_load;
  logic [2:0]  processo_atual;
  logic        busy;
`ifdef SCHED_STATS_EN
  logic [31:0] switch_count;
  logic [31:0] io_block_count;
`endif

  always #5 clock = ~clock;

  context_switch_scheduler dut (
    .clock               (clock),
    .reset               (reset),
    .troca_contexto      (troca_contexto),
    .io_contexto         (io_contexto),
    .fim_processo        (fim_processo),
    .pc_processo_trocado (pc_processo_trocado),
    .io_done             (io_done),
    .io_done_pid         (io_done_pid),
    .create_valid        (create_valid),
    .create_pid          (create_pid),
    .create_pc           (create_pc),
    .create_ready        (create_ready),
    .pc_novo             (pc_novo),
    .pc_load             (pc_load),
    .processo_atual      (processo_atual),
    .busy                (busy)
`ifdef SCHED_STATS_EN
    ,
    .switch_count        (switch_count),
    .io_block_count      (io_block_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: per-PID state/PC, cycles elapsed in the current switch, switch reason.
  int          m_st [N];
  logic [31:0] m_pc [N];
  int          m_stage;
  int          m_reason;
  int          m_pa;
  logic [31:0] m_pc_novo;
  int          m_pc_load;
  bit          m_pt, m_pi, m_pf;
  int unsigned m_sw, m_io;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = FREE;
      m_pc[i] = '0;
    end
    m_stage = 0; m_reason = 0; m_pa = 0;
    m_pc_novo = OS_PC; m_pc_load = 0;
    m_pt = 0; m_pi = 0; m_pf = 0;
    m_sw = 0; m_io = 0;
  endtask

  function automatic bit any_edge();
    return (fim_processo && !m_pf) || (io_contexto && !m_pi) || (troca_contexto && !m_pt);
  endfunction

  function automatic bit exp_create_ready();
    return (m_stage == 0) && !((m_pa != 0) && any_edge());
  endfunction

  function automatic bit any_ready();
    for (int p = 1; p < N; p++) if (m_st[p] == READY) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rr_pick(input int cur);
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (cur + k) % N;
      if ((p != 0) && (m_st[p] == READY)) return p;
    end
    return 0;
  endfunction

  task automatic model_step();
    bit ef, ei, et, cr;
    int nxt, pk;
    if (reset) begin
      model_reset();
      return;
    end
    ef = fim_processo && !m_pf;
    ei = io_contexto && !m_pi;
    et = troca_contexto && !m_pt;
    cr = exp_create_ready();
    nxt = m_stage;
    case (m_stage)
      0: begin
        if ((m_pa != 0) && (ef || ei || et)) begin
          m_reason = ef ? 2 : (ei ? 1 : 0);
          nxt = 1;
        end else if ((m_pa == 0) && any_ready()) begin
          nxt = 2;
        end
        if (create_valid && cr && (create_pid != 0) &&
            ((m_st[create_pid] == FREE) || (m_st[create_pid] == BLOCKED))) begin
          m_st[create_pid] = READY;
          m_pc[create_pid] = create_pc;
        end
      end
      1: begin
        if (m_reason == 0) begin
          m_st[m_pa] = READY;
          m_pc[m_pa] = pc_processo_trocado;
        end else if (m_reason == 1) begin
          m_st[m_pa] = BLOCKED;
          m_pc[m_pa] = pc_processo_trocado;
          m_io++;
        end else begin
          m_st[m_pa] = FREE;
        end
        nxt = 2;
      end
      2: begin
        pk = rr_pick(m_pa);
        if (pk != 0) begin
          m_st[pk] = RUNNING;
          m_pc_novo = m_pc[pk];
        end else begin
          m_pc_novo = OS_PC;
        end
        m_pa = pk;
        m_pc_load = 1;
        m_sw++;
        nxt = 3;
      end
      default: begin
        m_pc_load = 0;
        nxt = 0;
      end
    endcase
    if (io_done && (m_st[io_done_pid] == BLOCKED)) m_st[io_done_pid] = READY;
    m_pt = troca_contexto;
    m_pi = io_contexto;
    m_pf = fim_processo;
    m_stage = nxt;
  endtask

  task automatic compare_all();
    check("busy", busy, m_stage != 0);
    check("create_ready", create_ready, exp_create_ready());
    check("pc_load", pc_load, m_pc_load);
    check("pc_novo", pc_novo, m_pc_novo);
    check("processo_atual", processo_atual, m_pa);
`ifdef SCHED_STATS_EN
    check("switch_count", switch_count, m_sw);
    check("io_block_count", io_block_count, m_io);
`endif
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    #2 compare_all();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    troca_contexto = 0; io_contexto = 0; fim_processo = 0;
    pc_processo_trocado = '0;
    io_done = 0; io_done_pid = '0;
    create_valid = 0; create_pid = '0; create_pc = '0;
  endtask

  task automatic assert_reset();
    reset = 1;
    #1 model_reset();
  endtask

  int pulses;
  bit troca_pat [8] = '{1, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    reset = 1;
    clear_inputs();
    model_reset();
    @(negedge clock);
    #1;
    check("rst_pc_novo", pc_novo, OS_PC);
    check("rst_pc_load", pc_load, 0);
    check("rst_processo_atual", processo_atual, 0);
    check("rst_busy", busy, 0);
    @(negedge clock);
    tick();
    reset = 0;

    // OS dispatch of a freshly created process
    create_valid = 1; create_pid = 3'd1; create_pc = 32'h40;
    tick();
    create_valid = 0;
    tick(); tick();
    check("os_create_load", pc_load, 1);
    check("os_create_pc", pc_novo, 32'h40);
    check("os_create_pid", processo_atual, 1);
    tick();

    // Quantum expiry hands over to pid2, then round-robin back to pid1
    create_valid = 1; create_pid = 3'd2; create_pc = 32'h80;
    tick();
    create_valid = 0;
    troca_contexto = 1; pc_processo_trocado = 32'h55;
    tick();
    troca_contexto = 0;
    tick(); tick();
    check("troca_load", pc_load, 1);
    check("troca_pc", pc_novo, 32'h80);
    check("troca_pid", processo_atual, 2);
    tick();
    troca_contexto = 1; pc_processo_trocado = 32'h84;
    tick();
    troca_contexto = 0;
    tick(); tick();
    check("rr_back_pc", pc_novo, 32'h55);
    check("rr_back_pid", processo_atual, 1);
    tick();

    // fim and troca together: pid1 is freed and never comes back
    fim_processo = 1; troca_contexto = 1; pc_processo_trocado = 32'h66;
    tick();
    fim_processo = 0; troca_contexto = 0;
    tick(); tick();
    check("fim_wins_pid", processo_atual, 2);
    check("fim_wins_pc", pc_novo, 32'h84);
    tick();
    troca_contexto = 1; pc_processo_trocado = 32'h99;
    tick();
    troca_contexto = 0;
    tick(); tick();
    check("fim_not_reselected_pid", processo_atual, 2);
    check("fim_not_reselected_pc", pc_novo, 32'h99);
    tick();

    // Sole process blocks on I/O: OS runs until io_done makes it READY again
    io_contexto = 1; pc_processo_trocado = 32'h123;
    tick();
    io_contexto = 0;
    tick(); tick();
    check("io_os_load", pc_load, 1);
    check("io_os_pc", pc_novo, OS_PC);
    check("io_os_pid", processo_atual, 0);
    tick(); tick();
    io_done = 1; io_done_pid = 3'd2;
    tick();
    io_done = 0;
    tick(); tick();
    check("io_redispatch_load", pc_load, 1);
    check("io_redispatch_pc", pc_novo, 32'h123);
    check("io_redispatch_pid", processo_atual, 2);
    tick();

    // troca held high for 5 cycles gives a single switch
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      troca_contexto = (i < 5);
      tick();
      if (pc_load) pulses++;
    end
    check("troca_held_one_switch", pulses, 1);

    // Second rising edge arrives while busy and is dropped
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      troca_contexto = troca_pat[i];
      tick();
      if (pc_load) pulses++;
    end
    check("busy_edge_dropped", pulses, 1);

    // Reset in SELECT aborts the switch and clears the table
    troca_contexto = 1; pc_processo_trocado = 32'h777;
    tick();
    troca_contexto = 0;
    tick();
    assert_reset();
    check("abort_busy", busy, 0);
    check("abort_pc_load", pc_load, 0);
    check("abort_pc_novo", pc_novo, OS_PC);
    check("abort_pid", processo_atual, 0);
    tick();
    reset = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pc_load) pulses++;
    end
    check("abort_no_dispatch", pulses, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      troca_contexto      = ($urandom_range(0, 3) == 0);
      io_contexto         = ($urandom_range(0, 7) == 0);
      fim_processo        = ($urandom_range(0, 11) == 0);
      pc_processo_trocado = $urandom;
      io_done             = ($urandom_range(0, 5) == 0);
      io_done_pid         = 3'($urandom_range(0, N - 1));
      create_valid        = ($urandom_range(0, 2) == 0);
      create_pid          = 3'($urandom_range(0, N - 1));
      create_pc           = $urandom;
      if (i == 1500) assert_reset();
      tick();
      if (i == 1500) reset = 0;
    end

    clear_inputs();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
